// File: rtl/sound_sequencer_if.sv
// Handshake bundle between collision logic, the sound sequencer and the oscillator.
// The master drives the collision levels and the slave drives the oscillator controls.
interface sound_sequencer_if #(
  parameter int PERIOD_W = 16
);
  logic                goodColl;
  logic                badColl;
  logic                osc_en;
  logic [PERIOD_W-1:0] osc_period;
  logic                busy;
  logic                melody;
  logic                done;

  modport master (
    output goodColl, badColl,
    input  osc_en, osc_period, busy, melody, done
  );

  modport slave (
    input  goodColl, badColl,
    output osc_en, osc_period, busy, melody, done
  );
endinterface

// File: rtl/sound_sequencer.sv
// Plays a fixed GOOD or BAD melody on the oscillator in response to collision strobes.
// Notes and gaps are timed by one down-counter, and every output is registered.
module sound_sequencer #(
  parameter int NOTE_CYCLES = 1000,
  parameter int GAP_CYCLES  = 100,
  parameter int PERIOD_W    = 16
) (
  input logic               clk,
  input logic               nRst,
  sound_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_e;

  localparam int MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                melody_q, melody_d;
  logic                good_q, bad_q, armed_q;
  logic                osc_en_q, osc_en_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                finish;
  logic                g_req, b_req, last_note, expired;

  function automatic logic [PERIOD_W-1:0] note_period(input logic mel, input logic [1:0] idx);
    logic [PERIOD_W-1:0] p;
    p = '0;
    case ({mel, idx})
      3'b0_00: p = PERIOD_W'(400);
      3'b0_01: p = PERIOD_W'(300);
      3'b1_00: p = PERIOD_W'(300);
      3'b1_01: p = PERIOD_W'(450);
      3'b1_10: p = PERIOD_W'(600);
      default: p = '0;
    endcase
    return p;
  endfunction

  // A level already high when reset releases is absorbed by the first edge, not seen as a rise.
  assign g_req     = armed_q & bus.goodColl & ~good_q;
  assign b_req     = armed_q & bus.badColl  & ~bad_q;
  assign last_note = melody_q ? (idx_q == 2'd2) : (idx_q == 2'd1);
  assign expired   = (cnt_q == '0);

  // NOTE: nRst is sampled only on the clock edge; every flop, the counter included, is cleared.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      melody_q <= 1'b0;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
      armed_q  <= 1'b0;
      osc_en_q <= 1'b0;
      period_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      melody_q <= melody_d;
      good_q   <= bus.goodColl;
      bad_q    <= bus.badColl;
      armed_q  <= 1'b1;
      osc_en_q <= osc_en_d;
      period_q <= period_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so that no path through this block infers a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    melody_d = melody_q;
    finish   = 1'b0;
    if (b_req) begin
      state_d  = NOTE;
      idx_d    = '0;
      cnt_d    = NOTE_LOAD;
      melody_d = 1'b1;
    end else if (g_req && !(state_q != IDLE && melody_q)) begin
      state_d  = NOTE;
      idx_d    = '0;
      cnt_d    = NOTE_LOAD;
      melody_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        NOTE: begin
          if (!expired) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (last_note) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end
        GAP: begin
          if (!expired) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = NOTE;
            idx_d   = idx_q + 2'd1;
            cnt_d   = NOTE_LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and then registered.
  always_comb begin
    osc_en_d = (state_d == NOTE);
    period_d = (state_d == NOTE) ? note_period(melody_d, idx_d) : '0;
    busy_d   = (state_d != IDLE);
    done_d   = finish;
  end

  assign bus.osc_en     = osc_en_q;
  assign bus.osc_period = period_q;
  assign bus.busy       = busy_q;
  assign bus.melody     = melody_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: a timeline model of the melodies is checked every
// cycle, alongside directed literal checks of the key moments of each scenario.
module tb_sound_sequencer;
  localparam int N  = 20;
  localparam int G  = 5;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  sound_sequencer_if #(.PERIOD_W(PW)) bus ();

  sound_sequencer #(.NOTE_CYCLES(N), .GAP_CYCLES(G), .PERIOD_W(PW)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a melody is a start point plus elapsed cycles; outputs follow from arithmetic.
  int unsigned per_tab [2][3] = '{'{400, 300, 0}, '{300, 450, 600}};
  bit m_started = 0;
  bit m_armed, m_prevg, m_prevb, m_active, m_mel, m_done;
  bit greq, breq;
  int m_e;

  function automatic int mel_len(input bit m);
    return m ? (3 * N + 2 * G) : (2 * N + G);
  endfunction

  always @(posedge clk) begin
    m_started = 1;
    if (!nRst) begin
      m_armed = 0; m_prevg = 0; m_prevb = 0;
      m_active = 0; m_mel = 0; m_done = 0; m_e = 0;
    end else begin
      greq = m_armed && bus.goodColl && !m_prevg;
      breq = m_armed && bus.badColl && !m_prevb;
      m_prevg = bus.goodColl;
      m_prevb = bus.badColl;
      m_armed = 1;
      m_done  = 0;
      if (breq) begin
        m_active = 1; m_mel = 1; m_e = 0;
      end else if (greq && !(m_active && m_mel)) begin
        m_active = 1; m_mel = 0; m_e = 0;
      end else if (m_active) begin
        m_e++;
        if (m_e == mel_len(m_mel)) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int pos, note;
    bit exp_en;
    int unsigned exp_per;
    if (m_started) begin
      pos     = m_e % (N + G);
      note    = m_e / (N + G);
      exp_en  = m_active && (pos < N);
      exp_per = (exp_en && note < 3) ? per_tab[m_mel][note] : 0;
      check("model_osc_en", 32'(bus.osc_en), 32'(exp_en));
      check("model_osc_period", 32'(bus.osc_period), exp_per);
      check("model_busy", 32'(bus.busy), 32'(m_active));
      check("model_melody", 32'(bus.melody), 32'(m_mel));
      check("model_done", 32'(bus.done), 32'(m_done));
    end
  end

  // Each posedge accumulates the outputs held during the cycle that just ended.
  int busy_cnt = 0, done_cnt = 0, p400_cnt = 0;
  always @(posedge clk) begin
    if (m_started) begin
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      p400_cnt += (bus.osc_period == 16'd400) ? 1 : 0;
    end
  end

  int b0, d0, p0;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b0 = busy_cnt; d0 = done_cnt; p0 = p400_cnt;
  endtask

  initial begin
    nRst = 1'b0;
    bus.goodColl = 1'b0;
    bus.badColl  = 1'b0;
    step(2);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_period", 32'(bus.osc_period), 0);
    nRst = 1'b1;
    step(3);

    // GOOD melody from a 5-cycle pulse
    snap();
    bus.goodColl = 1'b1;
    step(1);
    check("good_first_period", 32'(bus.osc_period), 400);
    check("good_melody", 32'(bus.melody), 0);
    step(4);
    bus.goodColl = 1'b0;
    step(16);
    check("good_gap_period", 32'(bus.osc_period), 0);
    check("good_gap_busy", 32'(bus.busy), 1);
    step(5);
    check("good_second_period", 32'(bus.osc_period), 300);
    step(20);
    check("good_done", 32'(bus.done), 1);
    check("good_idle", 32'(bus.busy), 0);
    step(5);
    check("good_busy_cycles", 32'(busy_cnt - b0), 45);
    check("good_done_count", 32'(done_cnt - d0), 1);

    // BAD melody from a single edge
    snap();
    bus.badColl = 1'b1;
    step(1);
    check("bad_first_period", 32'(bus.osc_period), 300);
    check("bad_melody", 32'(bus.melody), 1);
    step(2);
    bus.badColl = 1'b0;
    step(23);
    check("bad_second_period", 32'(bus.osc_period), 450);
    step(25);
    check("bad_third_period", 32'(bus.osc_period), 600);
    step(20);
    check("bad_done", 32'(bus.done), 1);
    step(5);
    check("bad_busy_cycles", 32'(busy_cnt - b0), 70);
    check("bad_done_count", 32'(done_cnt - d0), 1);

    // BAD preempts GOOD; a GOOD edge during BAD is dropped
    snap();
    bus.goodColl = 1'b1;
    step(10);
    bus.badColl = 1'b1;
    step(1);
    check("preempt_period", 32'(bus.osc_period), 300);
    check("preempt_melody", 32'(bus.melody), 1);
    bus.goodColl = 1'b0;
    bus.badColl  = 1'b0;
    step(5);
    bus.goodColl = 1'b1;
    step(1);
    check("drop_melody", 32'(bus.melody), 1);
    check("drop_period", 32'(bus.osc_period), 300);
    step(3);
    bus.goodColl = 1'b0;
    step(61);
    check("preempt_done", 32'(bus.done), 1);
    step(5);
    check("preempt_busy_cycles", 32'(busy_cnt - b0), 80);
    check("preempt_done_count", 32'(done_cnt - d0), 1);

    // Simultaneous requests: BAD wins, GOOD never sounds
    snap();
    bus.goodColl = 1'b1;
    bus.badColl  = 1'b1;
    step(1);
    check("simul_melody", 32'(bus.melody), 1);
    check("simul_period", 32'(bus.osc_period), 300);
    step(2);
    bus.goodColl = 1'b0;
    bus.badColl  = 1'b0;
    step(73);
    check("simul_busy_cycles", 32'(busy_cnt - b0), 70);
    check("simul_done_count", 32'(done_cnt - d0), 1);
    check("simul_no_good", 32'(p400_cnt - p0), 0);

    // GOOD restarted during its second note
    snap();
    bus.goodColl = 1'b1;
    step(1);
    step(2);
    bus.goodColl = 1'b0;
    step(28);
    check("restart_before", 32'(bus.osc_period), 300);
    bus.goodColl = 1'b1;
    step(1);
    check("restart_period", 32'(bus.osc_period), 400);
    step(2);
    bus.goodColl = 1'b0;
    step(42);
    check("restart_still_busy", 32'(bus.busy), 1);
    step(1);
    check("restart_done", 32'(bus.done), 1);
    step(5);
    check("restart_busy_cycles", 32'(busy_cnt - b0), 76);
    check("restart_done_count", 32'(done_cnt - d0), 1);

    // Reset mid-BAD, released with levels high
    bus.badColl = 1'b1;
    step(30);
    check("pre_reset_period", 32'(bus.osc_period), 450);
    bus.goodColl = 1'b1;
    nRst = 1'b0;
    step(1);
    check("mid_reset_osc_en", 32'(bus.osc_en), 0);
    check("mid_reset_period", 32'(bus.osc_period), 0);
    check("mid_reset_busy", 32'(bus.busy), 0);
    check("mid_reset_melody", 32'(bus.melody), 0);
    check("mid_reset_done", 32'(bus.done), 0);
    step(1);
    nRst = 1'b1;
    step(1);
    check("release_busy", 32'(bus.busy), 0);
    step(10);
    check("release_still_idle", 32'(bus.busy), 0);
    check("release_osc_en", 32'(bus.osc_en), 0);
    bus.goodColl = 1'b0;
    bus.badColl  = 1'b0;
    step(3);
    bus.goodColl = 1'b1;
    step(1);
    check("post_reset_good", 32'(bus.osc_period), 400);
    bus.goodColl = 1'b0;
    step(50);
    check("post_reset_idle", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Event-driven controller for the game's sound oscillator. It watches the collision strobes from game logic, arbitrates between them, and plays a short fixed melody per event. Each note drives the oscillator's enable and period for a programmed number of clock cycles, with silent gaps between notes. It sits between collision detection and the oscillator, which consumes `osc_en` and `osc_period`.

## Interface
- `NOTE_CYCLES`, default 1000: clock cycles each note sounds.
- `GAP_CYCLES`, default 100: silent clock cycles between consecutive notes; must be ≥1.
- `PERIOD_W`, default 16: width of `osc_period`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `nRst`  in  1  reset; synchronous, active-low.
- `goodColl`  in  1  level from game logic; a rising edge requests the GOOD melody.
- `badColl`  in  1  level from game logic; a rising edge requests the BAD melody.
- `osc_en`  out  1  oscillator run enable; high only while a note sounds.
- `osc_period`  out  PERIOD_W  oscillator half-period count for the current note; 0 when not sounding.
- `busy`  out  1  high in any state other than IDLE.
- `melody`  out  1  melody in play: 0 = GOOD, 1 = BAD; held at its last value in IDLE.
- `done`  out  1  one-cycle pulse when a melody completes normally.

## Operation
- Edge detect: `goodColl` and `badColl` are registered each cycle. A request `g_req` or `b_req` is the input high while its registered copy is low. Holding a level high never retriggers.
- Melody table, fixed constants, zero-extended to PERIOD_W:
  - GOOD: 2 notes, periods 400, 300 (rising pitch).
  - BAD: 3 notes, periods 300, 450, 600 (falling pitch).
- States:
  - IDLE: `osc_en`=0, `osc_period`=0, `busy`=0.
  - NOTE: `osc_en`=1, `osc_period`=table[melody][idx].
  - GAP: `osc_en`=0, `osc_period`=0.
- Note index `idx` is 2 bits. The duration counter is wide enough for max(NOTE_CYCLES, GAP_CYCLES).
- Transitions:
  - IDLE → NOTE on a request. `idx`=0, counter loaded, `melody` set per arbitration.
  - NOTE → GAP when the counter expires, if `idx` is not the last note.
  - NOTE → IDLE when the counter expires on the last note. `done`=1 for that one cycle. There is no trailing gap.
  - GAP → NOTE when the counter expires; `idx` increments.
- Arbitration, which applies in every state:
  - `b_req` and `g_req` in the same cycle: BAD wins and the GOOD request is dropped.
  - `b_req` while any melody plays, BAD included: restart BAD at `idx` 0, NOTE state, fresh counter.
  - `g_req` while GOOD plays: restart GOOD at `idx` 0.
  - `g_req` while BAD plays: dropped, not queued.
  - A preempted or restarted melody does not pulse `done`.
  - A restart takes priority over a counter expiry in the same cycle.
- No request queueing; at most one melody is active.

## Timing
- Reset: the first rising edge with `nRst`=0 drives IDLE, `osc_en`=0, `osc_period`=0, `busy`=0, `melody`=0, `done`=0, `idx`=0, counter=0, and edge registers=0. This also applies when reset arrives mid-melody.
- Request latency: an input found high at edge k (and low at edge k−1) gives `osc_en`=1, `busy`=1 and the first-note period visible after edge k.
- Each note: `osc_en` is high for exactly NOTE_CYCLES cycles. Each gap: low for exactly GAP_CYCLES cycles.
- Total busy time:
  - GOOD: 2·NOTE_CYCLES + GAP_CYCLES cycles.
  - BAD: 3·NOTE_CYCLES + 2·GAP_CYCLES cycles.
- `done` is asserted in the cycle `busy` falls, i.e. the first IDLE cycle.
- Back-to-back: a request in the cycle `done` is high starts the new melody at the following edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench uses NOTE_CYCLES=20, GAP_CYCLES=5.
- Reset: hold `nRst`=0 mid-BAD-note, one edge → all outputs 0. Release with `goodColl` already high → no melody starts, since there is no edge.
- GOOD: pulse `goodColl` for 5 cycles → expected output:
  - `osc_period`=400 for 20 cycles, then 0 for 5, then 300 for 20.
  - `busy` high 45 cycles, `melody`=0, one `done` pulse.
  - No retrigger from the held level.
- BAD: single `badColl` edge → expected output:
  - Periods 300, 450, 600, each 20 cycles, with 5-cycle gaps.
  - `busy` high 70 cycles, `melody`=1, one `done` pulse.
- Preemption and drop:
  - `badColl` edge 10 cycles into GOOD note 0 → next cycle period=300, `melody`=1, full 70-cycle BAD, no `done` for GOOD.
  - `goodColl` edge during BAD → ignored.
- Simultaneous requests: `goodColl` and `badColl` rise in the same cycle → BAD plays and GOOD is never heard.
- Restart: a second `goodColl` edge during GOOD note 1 → `idx` returns to 0, period=400, `busy` extends to 45 cycles from the restart, single `done` at the end.
